// File: rtl/rob_retire_pkg.sv
// ---------------------------------------------------------------------------
// pipTypes : shared pipeline types for the reorder-buffer retire stage.
//
// Contents
//   rob_entry_t    : ROB entry as seen by the retire stage (result, destination
//                    register, destination-valid flag, store flag).
//   retire_state_t : retire FSM states RUN / WAIT_ST.
//   clogb2         : ceiling log2, used to size index and count fields.
// ---------------------------------------------------------------------------
package pipTypes;

    typedef struct packed {
        logic [31:0] result_lo;
        logic [4:0]  dest_reg;
        logic        dest_reg_valid;
        logic        is_store;
    } rob_entry_t;

    // Single-bit encoding so that WAIT_ST decodes straight from one flop.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_ST = 1'b1
    } retire_state_t;

    // Smallest r such that 2**r >= value.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// ---------------------------------------------------------------------------
// retire_select : combinational in-order prefix scan over the ROB head slots.
//
// Ports
//   i_valid     : per-slot completed/occupied flags (bit 0 = oldest)
//   i_kill      : per-slot squashed flags
//   i_isStore   : per-slot store flags
//   i_destValid : per-slot destination-register-valid flags
//   i_destReg   : per-slot destination register numbers
//   i_empty     : ROB empty; nothing is eligible while set
//   o_eligible  : eligibility mask of the retiring prefix
//   o_count     : number of eligible slots (0..EXT_COUNT)
//   o_wrEnable  : register-write mask, deduplicated so that only the
//                 youngest writer of a given register keeps its enable
// ---------------------------------------------------------------------------
module retire_select
    import pipTypes::*;
#(
    parameter int EXT_COUNT = 4,
    parameter int CNTW      = 3
) (
    input  logic [EXT_COUNT-1:0] i_valid,
    input  logic [EXT_COUNT-1:0] i_kill,
    input  logic [EXT_COUNT-1:0] i_isStore,
    input  logic [EXT_COUNT-1:0] i_destValid,
    input  logic [4:0]           i_destReg [EXT_COUNT],
    input  logic                 i_empty,
    output logic [EXT_COUNT-1:0] o_eligible,
    output logic [CNTW-1:0]      o_count,
    output logic [EXT_COUNT-1:0] o_wrEnable
);

    logic                 w_chainOk;
    logic [EXT_COUNT-1:0] w_cand;

    // Walk from the oldest slot; the first invalid slot or live store breaks
    // the chain, so everything younger is held this cycle. A live store is
    // never eligible here: it retires through the LSU handshake instead.
    always_comb begin
        w_chainOk  = !i_empty;
        o_eligible = '0;
        o_count    = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            if (w_chainOk && i_valid[i] && !(i_isStore[i] && !i_kill[i])) begin
                o_eligible[i] = 1'b1;
                o_count       = o_count + CNTW'(1);
            end else begin
                w_chainOk = 1'b0;
            end
        end
    end

    // A lane writes when it retires live with a real destination (r0 is never
    // written). When a younger retiring lane hits the same register, the older
    // write is dropped so the file ends with the architecturally last value.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < EXT_COUNT; i++) begin
            w_cand[i] = o_eligible[i] & !i_kill[i] & i_destValid[i] &
                        (i_destReg[i] != 5'd0);
        end
        o_wrEnable = w_cand;
        for (int i = 0; i < EXT_COUNT; i++) begin
            for (int j = i + 1; j < EXT_COUNT; j++) begin
                if (w_cand[j] && (i_destReg[j] == i_destReg[i])) begin
                    o_wrEnable[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/rob_retire.sv
// ---------------------------------------------------------------------------
// rob_retire : in-order commit stage at the consume end of the reorder buffer.
//
// Each cycle the longest eligible in-order prefix of the EXT_COUNT head slots
// is popped (consume / consume_count) and its results are written to the
// register file one cycle later. A live store at the head is committed via a
// request/acknowledge handshake with the LSU before it leaves the ROB.
//
// Ports
//   clock, reset        : clock, asynchronous active-high reset
//   slot_data/valid/kill: ROB head slots, index 0 is the oldest
//   empty               : ROB is empty
//   consume             : pop request (combinational)
//   consume_count       : popped slots minus one
//   rf_wr_en/reg/data   : registered register-file write port per lane
//   st_commit_req/idx   : store commit request and its ROB index
//   st_commit_ack       : LSU has committed the store
//   head_idx            : mirror of the ROB extract pointer
//   retired_count, killed_count, store_stall_cycles : performance counters
//
// Configuration macro
//   RETIRE_PERF_EN : when defined the three counters are live, wrapping 32-bit
//                    counters; otherwise they read as 0 and no flops exist.
// ---------------------------------------------------------------------------
module rob_retire
    import pipTypes::*;
#(
    parameter int  DEPTH        = 16,
    parameter int  EXT_COUNT    = 4,
    parameter type T            = rob_entry_t,
    parameter int  DEPTHLOG2    = clogb2(DEPTH),
    parameter int  EXTCOUNTLOG2 = clogb2(EXT_COUNT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  T                        slot_data  [EXT_COUNT],
    input  logic                    slot_valid [EXT_COUNT],
    input  logic                    slot_kill  [EXT_COUNT],
    input  logic                    empty,
    output logic                    consume,
    output logic [EXTCOUNTLOG2-1:0] consume_count,
    output logic                    rf_wr_en   [EXT_COUNT],
    output logic [4:0]              rf_wr_reg  [EXT_COUNT],
    output logic [31:0]             rf_wr_data [EXT_COUNT],
    output logic                    st_commit_req,
    output logic [DEPTHLOG2-1:0]    st_commit_idx,
    input  logic                    st_commit_ack,
    output logic [DEPTHLOG2-1:0]    head_idx,
    output logic [31:0]             retired_count,
    output logic [31:0]             killed_count,
    output logic [31:0]             store_stall_cycles
);

    localparam int CNTW  = EXTCOUNTLOG2 + 1;
    localparam int HEADW = DEPTHLOG2 + 1;

    logic [EXT_COUNT-1:0] w_valid;
    logic [EXT_COUNT-1:0] w_kill;
    logic [EXT_COUNT-1:0] w_isStore;
    logic [EXT_COUNT-1:0] w_destValid;
    logic [4:0]           w_destReg [EXT_COUNT];

    logic [EXT_COUNT-1:0] w_scanElig;
    logic [EXT_COUNT-1:0] w_scanWe;
    logic [CNTW-1:0]      w_scanCount;

    retire_state_t        r_state;
    retire_state_t        w_nextState;
    logic [DEPTHLOG2-1:0] r_headIdx;

    logic [CNTW-1:0]      w_count;
    logic [CNTW-1:0]      w_countMinusOne;
    logic                 w_consume;
    logic [EXT_COUNT-1:0] w_retMask;
    logic [EXT_COUNT-1:0] w_weMask;
    logic                 w_headStore;
    logic                 w_writeCand0;
    logic [HEADW-1:0]     w_headSum;
    logic [HEADW-1:0]     w_headWrapped;

    logic [EXT_COUNT-1:0] r_wrEn;
    logic [4:0]           r_wrReg  [EXT_COUNT];
    logic [31:0]          r_wrData [EXT_COUNT];

    // Flatten the per-slot fields the scan needs into simple vectors.
    always_comb begin
        for (int k = 0; k < EXT_COUNT; k++) begin
            w_valid[k]     = slot_valid[k];
            w_kill[k]      = slot_kill[k];
            w_isStore[k]   = slot_data[k].is_store;
            w_destValid[k] = slot_data[k].dest_reg_valid;
            w_destReg[k]   = slot_data[k].dest_reg;
        end
    end

    retire_select #(
        .EXT_COUNT (EXT_COUNT),
        .CNTW      (CNTW)
    ) u_select (
        .i_valid     (w_valid),
        .i_kill      (w_kill),
        .i_isStore   (w_isStore),
        .i_destValid (w_destValid),
        .i_destReg   (w_destReg),
        .i_empty     (empty),
        .o_eligible  (w_scanElig),
        .o_count     (w_scanCount),
        .o_wrEnable  (w_scanWe)
    );

    assign w_headStore  = !empty & w_valid[0] & w_isStore[0] & !w_kill[0];
    assign w_writeCand0 = !w_kill[0] & w_destValid[0] & (w_destReg[0] != 5'd0);

    // Retire decision for this cycle. In RUN the scan result is used as is;
    // in WAIT_ST only the head store may leave, and only once the LSU acks.
    always_comb begin
        w_nextState = r_state;
        w_count     = '0;
        w_retMask   = '0;
        w_weMask    = '0;
        case (r_state)
            RUN: begin
                if (w_scanCount != '0) begin
                    w_count   = w_scanCount;
                    w_retMask = w_scanElig;
                    w_weMask  = w_scanWe;
                end else if (w_headStore) begin
                    w_nextState = WAIT_ST;
                end
            end
            WAIT_ST: begin
                if (st_commit_ack) begin
                    w_count      = CNTW'(1);
                    w_retMask[0] = 1'b1;
                    w_weMask[0]  = w_writeCand0;
                    w_nextState  = RUN;
                end
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    assign w_consume       = (w_count != '0);
    assign w_countMinusOne = w_count - CNTW'(1);
    assign consume         = w_consume;
    assign consume_count   = w_consume ? w_countMinusOne[EXTCOUNTLOG2-1:0] : '0;

    // The state is a single flop, so the request is glitch-free.
    assign st_commit_req = (r_state == WAIT_ST);
    assign st_commit_idx = r_headIdx;
    assign head_idx      = r_headIdx;

    // Modulo-DEPTH advance that also holds for non-power-of-two depths.
    assign w_headSum     = {1'b0, r_headIdx} + HEADW'(w_count);
    assign w_headWrapped = (w_headSum >= HEADW'(DEPTH)) ? (w_headSum - HEADW'(DEPTH))
                                                        : w_headSum;

    // FSM state and extract-pointer mirror.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_headIdx <= '0;
        end else begin
            r_state   <= w_nextState;
            r_headIdx <= DEPTHLOG2'(w_headWrapped);
        end
    end

    // Register-file write port, one cycle behind the consume. Address and data
    // follow every retiring lane; only the enable says whether it is a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrEn <= '0;
            for (int k = 0; k < EXT_COUNT; k++) begin
                r_wrReg[k]  <= '0;
                r_wrData[k] <= '0;
            end
        end else begin
            r_wrEn <= w_weMask;
            for (int k = 0; k < EXT_COUNT; k++) begin
                if (w_retMask[k]) begin
                    r_wrReg[k]  <= w_destReg[k];
                    r_wrData[k] <= slot_data[k].result_lo;
                end
            end
        end
    end

    // Drive the unpacked write-port outputs from the packed registers.
    always_comb begin
        for (int k = 0; k < EXT_COUNT; k++) begin
            rf_wr_en[k]   = r_wrEn[k];
            rf_wr_reg[k]  = r_wrReg[k];
            rf_wr_data[k] = r_wrData[k];
        end
    end

`ifdef RETIRE_PERF_EN
    logic [31:0] r_retiredCount;
    logic [31:0] r_killedCount;
    logic [31:0] r_stallCount;

    // Wrapping event counters: live and killed retirements, and every cycle
    // spent waiting on the LSU (the ack cycle included).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retiredCount <= '0;
            r_killedCount  <= '0;
            r_stallCount   <= '0;
        end else begin
            r_retiredCount <= r_retiredCount + 32'($countones(w_retMask & ~w_kill));
            r_killedCount  <= r_killedCount + 32'($countones(w_retMask & w_kill));
            if (r_state == WAIT_ST) begin
                r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end

    assign retired_count      = r_retiredCount;
    assign killed_count       = r_killedCount;
    assign store_stall_cycles = r_stallCount;
`else
    assign retired_count      = '0;
    assign killed_count       = '0;
    assign store_stall_cycles = '0;
`endif

endmodule
